// File: rtl/tree_node_aggregator.sv
// Round-robin N_CHILD:1 beat aggregator feeding a registered upstream FIFO.
// Define TREE_NODE_LOCK_EN to hold the grant on a child until its last beat is accepted.
module tree_node_aggregator #(
  parameter int N_CHILD    = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (N_CHILD > 1) ? $clog2(N_CHILD) : 1,
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CHILD-1:0]          child_valid,
  input  logic [N_CHILD*DATA_W-1:0]   child_data,
  input  logic [N_CHILD-1:0]          child_last,
  output logic [N_CHILD-1:0]          child_ready,
  output logic                        up_valid,
  output logic [DATA_W-1:0]           up_data,
  output logic [ID_W-1:0]             up_id,
  output logic                        up_last,
  input  logic                        up_ready,
  output logic [OCC_W-1:0]            occupancy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] child_data_arr [N_CHILD];
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   rr_id;
  logic              rr_found;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic              full;
  logic              accept;
  logic              pop;

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]   mem_id_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q;

  for (genvar gi = 0; gi < N_CHILD; gi++) begin : g_child
    assign child_data_arr[gi] = child_data[gi*DATA_W +: DATA_W];
    assign child_ready[gi]    = accept && (gnt_id == ID_W'(gi));
  end

  // Walk downward so the candidate closest to ptr (highest priority) is written last.
  always_comb begin
    logic [ID_W:0] cand;
    rr_found = 1'b0;
    rr_id    = '0;
    cand     = '0;
    for (int k = N_CHILD - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_CHILD)) begin
        cand = cand - (ID_W+1)'(N_CHILD);
      end
      if (child_valid[cand[ID_W-1:0]]) begin
        rr_found = 1'b1;
        rr_id    = cand[ID_W-1:0];
      end
    end
  end

`ifdef TREE_NODE_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;

  // A locked child keeps the grant even while idle; nobody else may be served.
  always_comb begin
    gnt_any = rr_found;
    gnt_id  = rr_id;
    if (lock_q) begin
      gnt_any = child_valid[lock_id_q];
      gnt_id  = lock_id_q;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d    = !child_last[gnt_id];
      lock_id_d = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  assign gnt_any = rr_found;
  assign gnt_id  = rr_id;
`endif

  assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
  assign accept   = rst_n && gnt_any && !full;
  assign up_valid = (occ_q != '0);
  assign pop      = up_valid && up_ready;

  assign up_data   = mem_data_q[rd_ptr_q];
  assign up_id     = mem_id_q[rd_ptr_q];
  assign up_last   = mem_last_q[rd_ptr_q];
  assign occupancy = occ_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == ID_W'(N_CHILD - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared on reset so the idle upstream bus reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      mem_last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
      if (accept) begin
        mem_data_q[wr_ptr_q] <= child_data_arr[gnt_id];
        mem_id_q[wr_ptr_q]   <= gnt_id;
        mem_last_q[wr_ptr_q] <= child_last[gnt_id];
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tree_node_aggregator.sv
// Scoreboard bench for tree_node_aggregator: a reference arbiter/FIFO model predicts every beat.
// Build with TREE_NODE_LOCK_EN defined to also exercise packet locking.
module tb_tree_node_aggregator;

  localparam int NC = 5;
  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] child_valid;
  logic [NC*DW-1:0] child_data;
  logic [NC-1:0] child_last;
  logic [NC-1:0] child_ready;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic [2:0]    up_id;
  logic          up_last;
  logic          up_ready;
  logic [2:0]    occupancy;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] sb_q[$];
  int m_ptr = 0;
  int m_occ = 0;
  bit m_lock = 0;
  int m_lock_id = 0;

  tree_node_aggregator #(.N_CHILD(NC), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_last  (child_last),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_id       (up_id),
    .up_last     (up_last),
    .up_ready    (up_ready),
    .occupancy   (occupancy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluated mid-cycle, it predicts ready/occupancy and the head beat.
  initial begin : model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_val("rst_occ", 32'(occupancy), 32'd0);
        check_val("rst_valid", 32'(up_valid), 32'd0);
        check_val("rst_data", 32'(up_data), 32'd0);
        check_val("rst_id", 32'(up_id), 32'd0);
        check_val("rst_last", 32'(up_last), 32'd0);
        check_val("rst_ready", 32'(child_ready), 32'd0);
        m_ptr = 0;
        m_occ = 0;
        m_lock = 0;
        m_lock_id = 0;
        sb_q.delete();
      end else begin
        bit acc;
        bit pp;
        int g;
        logic [NC-1:0] exp_rdy;
        acc = 0;
        g = 0;
        if (m_occ < FD) begin
          if (m_lock) begin
            if (child_valid[m_lock_id[2:0]]) begin
              acc = 1;
              g = m_lock_id;
            end
          end else begin
            for (int k = 0; k < NC; k++) begin
              int c;
              c = (m_ptr + k) % NC;
              if (!acc && child_valid[c[2:0]]) begin
                acc = 1;
                g = c;
              end
            end
          end
        end
        exp_rdy = acc ? (NC'(1) << g) : '0;
        check_val("child_ready", 32'(child_ready), 32'(exp_rdy));
        check_val("occupancy", 32'(occupancy), 32'(m_occ));
        check_val("up_valid", 32'(up_valid), 32'(m_occ != 0));
        pp = (m_occ != 0) && up_ready;
        if (m_occ != 0 && sb_q.size() != 0) begin
          check_val(pp ? "beat" : "hold", 32'({up_id, up_data, up_last}), 32'(sb_q[0]));
          if (pp) begin
            $display("pop id=%0d data=%02h last=%0d", up_id, up_data, up_last);
            void'(sb_q.pop_front());
          end
        end
        if (acc) begin
          sb_q.push_back({g[2:0], child_data[g*DW +: DW], child_last[g[2:0]]});
          m_ptr = (g + 1) % NC;
`ifdef TREE_NODE_LOCK_EN
          m_lock = !child_last[g[2:0]];
          m_lock_id = g;
`endif
        end
        m_occ = m_occ + int'(acc) - int'(pp);
      end
    end
  end

  initial begin : stim
    rst_n = 1;
    up_ready = 0;
    child_valid = '0;
    child_data = '0;
    child_last = '0;
    #1 rst_n = 0;
    child_valid = 5'b00010;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    child_valid = '0;

    // All children streaming, upstream always ready: one beat per cycle in id order.
    up_ready = 1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NC; i++) child_data[i*DW +: DW] = 8'(i*16 + c);
      child_valid = '1;
      child_last = '1;
      tick();
      check_val("rr_id", 32'(up_id), 32'(c % NC));
      check_val("rr_occ", 32'(occupancy), 32'd1);
    end
    child_valid = '0;
    repeat (2) tick();

    // Child 2 fills the FIFO while upstream stalls, then pop-only on the full cycle.
    up_ready = 0;
    for (int k = 0; k < 4; k++) begin
      child_valid = 5'b00100;
      child_data[2*DW +: DW] = 8'(8'h10 + k);
      child_last[2] = (k == 3);
      tick();
    end
    child_data[2*DW +: DW] = 8'h14;
    child_last[2] = 1;
    @(negedge clk);
    check_val("full_occ", 32'(occupancy), 32'd4);
    check_val("full_rdy", 32'(child_ready), 32'd0);
    @(posedge clk);
    #1 up_ready = 1;
    @(posedge clk);
    #1 check_val("pop_only", 32'(occupancy), 32'd3);
    @(negedge clk);
    check_val("push_rdy", 32'(child_ready), 32'b00100);
    @(posedge clk);
    #1 check_val("push_occ", 32'(occupancy), 32'd3);
    child_valid = '0;
    repeat (5) tick();

    // Single beat into an empty FIFO appears one cycle later.
    child_valid = 5'b01000;
    child_data[3*DW +: DW] = 8'hA5;
    child_last[3] = 1;
    tick();
    check_val("single_vld", 32'(up_valid), 32'd1);
    check_val("single_id", 32'(up_id), 32'd3);
    check_val("single_data", 32'(up_data), 32'hA5);
    child_valid = '0;
    repeat (2) tick();

`ifdef TREE_NODE_LOCK_EN
    // Child 1 packet of three beats holds the grant against child 0.
    child_valid = 5'b00001;
    child_data[0 +: DW] = 8'hC0;
    child_last[0] = 1;
    tick();
    child_valid = 5'b00011;
    child_data[0 +: DW] = 8'hC1;
    for (int k = 0; k < 3; k++) begin
      child_data[DW +: DW] = 8'(8'hB0 + k);
      child_last[1] = (k == 2);
      tick();
      check_val("lock_id", 32'(up_id), 32'd1);
    end
    child_valid = 5'b00001;
    tick();
    check_val("unlock_id", 32'(up_id), 32'd0);
    child_valid = '0;
    repeat (2) tick();
`endif

    // Preload two beats, then reset mid-transfer.
    up_ready = 0;
    child_valid = 5'b00010;
    child_data[DW +: DW] = 8'h51;
    child_last[1] = 1;
    tick();
    child_data[DW +: DW] = 8'h52;
    tick();
    check_val("pre_rst_occ", 32'(occupancy), 32'd2);
    child_valid = 5'b00101;
    child_data[0 +: DW] = 8'h60;
    child_data[2*DW +: DW] = 8'h62;
    child_last[0] = 1;
    child_last[2] = 1;
    up_ready = 1;
    #2 rst_n = 0;
    #1;
    check_val("rst_async_occ", 32'(occupancy), 32'd0);
    check_val("rst_async_vld", 32'(up_valid), 32'd0);
    check_val("rst_async_rdy", 32'(child_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check_val("first_gnt", 32'(child_ready), 32'b00001);
    @(posedge clk);
    #1 child_valid = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
